// File: rtl/delivery_tracker_if.sv
// Ball/outcome strobes in, batting-team status and per-team view totals out.
// The master drives the strobes; the slave (tracker) drives the status.
interface delivery_tracker_if #(
   parameter int unsigned N_TEAMS = 2,
   parameter int unsigned CW      = 9
);
   localparam int unsigned TW = (N_TEAMS > 1) ? $clog2(N_TEAMS) : 1;

   logic          ball_pulse;
   logic [3:0]    delivery_code;
   logic          wicket_pulse;
   logic          next_inning;
   logic          game_over_in;
   logic [TW-1:0] view_team;
   logic [TW-1:0] cur_team;
   logic [CW-1:0] legal_balls;
   logic [5:0]    over_num;
   logic [3:0]    ball_in_over;
   logic          free_hit;
   logic          inning_over;
   logic          game_done;
   logic [CW-1:0] view_balls;
   logic [7:0]    view_extras;
   logic [3:0]    view_wkts;

   modport master (
      output ball_pulse, delivery_code, wicket_pulse, next_inning, game_over_in, view_team,
      input  cur_team, legal_balls, over_num, ball_in_over, free_hit, inning_over, game_done,
             view_balls, view_extras, view_wkts
   );

   modport slave (
      input  ball_pulse, delivery_code, wicket_pulse, next_inning, game_over_in, view_team,
      output cur_team, legal_balls, over_num, ball_in_over, free_hit, inning_over, game_done,
             view_balls, view_extras, view_wkts
   );
endinterface

// File: rtl/delivery_tracker.sv
// Counts legal balls, overs, extras and wickets for each innings in turn, tracks free hits,
// and sequences PLAY / BREAK / DONE across N_TEAMS innings.
module delivery_tracker #(
   parameter int unsigned N_TEAMS        = 2,
   parameter int unsigned BALLS_PER_OVER = 6,
   parameter int unsigned MAX_OVERS      = 20,
   parameter int unsigned MAX_WKTS       = 10,
   parameter int unsigned CW             = 9,
   parameter int unsigned WIDE_CODE      = 7,
   parameter int unsigned NOBALL_CODE    = 5
) (
   input logic               clk,
   input logic               rst,
   delivery_tracker_if.slave bus
);
   localparam int unsigned   TW       = (N_TEAMS > 1) ? $clog2(N_TEAMS) : 1;
   localparam logic [TW-1:0] LastTeam = TW'(N_TEAMS - 1);

   typedef enum logic [1:0] {StPlay, StBreak, StDone} state_e;
   state_e state_q, state_d;

   logic [TW-1:0] team_q;
   logic [5:0]    over_q, over_d;
   logic [3:0]    bio_q, bio_d;
   logic          fh_q, fh_d;
   logic [CW-1:0] balls_q  [N_TEAMS];
   logic [7:0]    extras_q [N_TEAMS];
   logic [3:0]    wkts_q   [N_TEAMS];
   logic [CW-1:0] balls_d;
   logic [7:0]    extras_d;
   logic [3:0]    wkts_d;
   logic          is_extra, deliver, start_inning, innings_end;

   assign is_extra     = (bus.delivery_code == 4'(WIDE_CODE)) ||
                         (bus.delivery_code == 4'(NOBALL_CODE));
   // game_over_in wins over a same-cycle delivery or innings change
   assign deliver      = (state_q == StPlay) && bus.ball_pulse && !bus.game_over_in;
   assign start_inning = (state_q == StBreak) && bus.next_inning && !bus.game_over_in;

   always_comb begin
      over_d   = over_q;
      bio_d    = bio_q;
      fh_d     = fh_q;
      balls_d  = balls_q[team_q];
      extras_d = extras_q[team_q];
      wkts_d   = wkts_q[team_q];
      if (deliver) begin
         if (is_extra) begin
            if (extras_d != 8'hff) extras_d = extras_d + 8'd1;
            if (bus.delivery_code == 4'(NOBALL_CODE)) fh_d = 1'b1;
         end else begin
            balls_d = balls_d + CW'(1);
            fh_d    = 1'b0;
            if (bus.wicket_pulse && !fh_q) wkts_d = wkts_d + 4'd1;
            if (bio_q == 4'(BALLS_PER_OVER - 1)) begin
               bio_d  = 4'd0;
               over_d = over_q + 6'd1;
            end else begin
               bio_d = bio_q + 4'd1;
            end
         end
      end
   end

   assign innings_end = deliver && ((over_d == 6'(MAX_OVERS)) || (wkts_d == 4'(MAX_WKTS)));

   always_ff @(posedge clk) begin
      if (!rst) state_q <= StPlay;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StPlay: begin
            if (bus.game_over_in)  state_d = StDone;
            else if (innings_end)  state_d = (team_q == LastTeam) ? StDone : StBreak;
         end
         StBreak: begin
            if (bus.game_over_in)     state_d = StDone;
            else if (bus.next_inning) state_d = StPlay;
         end
         StDone:  state_d = StDone;
         default: state_d = StPlay;
      endcase
   end

   always_comb begin
      bus.inning_over = (state_q != StPlay);
      bus.game_done   = (state_q == StDone);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         team_q <= '0;
         over_q <= '0;
         bio_q  <= '0;
         fh_q   <= 1'b0;
         for (int unsigned i = 0; i < N_TEAMS; i++) begin
            balls_q[i]  <= '0;
            extras_q[i] <= '0;
            wkts_q[i]   <= '0;
         end
      end else if (start_inning) begin
         team_q <= team_q + TW'(1);
         over_q <= '0;
         bio_q  <= '0;
         fh_q   <= 1'b0;
      end else if (deliver) begin
         over_q           <= over_d;
         bio_q            <= bio_d;
         fh_q             <= fh_d;
         balls_q[team_q]  <= balls_d;
         extras_q[team_q] <= extras_d;
         wkts_q[team_q]   <= wkts_d;
      end
   end

   assign bus.cur_team     = team_q;
   assign bus.legal_balls  = balls_q[team_q];
   assign bus.over_num     = over_q;
   assign bus.ball_in_over = bio_q;
   assign bus.free_hit     = fh_q;

   always_comb begin
      bus.view_balls  = '0;
      bus.view_extras = '0;
      bus.view_wkts   = '0;
      if (32'(bus.view_team) < N_TEAMS) begin
         bus.view_balls  = balls_q[bus.view_team];
         bus.view_extras = extras_q[bus.view_team];
         bus.view_wkts   = wkts_q[bus.view_team];
      end
   end
endmodule
